// File: rtl/input_port_ctrl_if.sv
// Handshake bundle between the input port controller and the core's IN path.
// The core side is the master: it raises in_req and pulses clr_overrun.
// The controller side is the slave: it presents the captured word and status.
interface input_port_ctrl_if #(
  parameter int DATA_W = 16
);

  logic              in_req;
  logic              clr_overrun;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              in_ack;
  logic              overrun;

  modport master (
    output in_req,
    output clr_overrun,
    input  data_out,
    input  valid,
    input  in_ack,
    input  overrun
  );

  modport slave (
    input  in_req,
    input  clr_overrun,
    output data_out,
    output valid,
    output in_ack,
    output overrun
  );

endinterface

// File: rtl/input_port_ctrl.sv
// Input port controller: synchronises and debounces the active-low check-in/out
// button, captures the switch word on each accepted press and holds it until the
// core consumes it with a request/acknowledge handshake.
module input_port_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20,
  parameter int DATA_W          = 16
) (
  input  logic              Clock,
  input  logic              n_reset,
  input  logic              Button,
  input  logic [DATA_W-1:0] Switches,
  input_port_ctrl_if.slave  port,
  output logic              btn_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    CHK_PRESS,
    PRESSED,
    CHK_RELEASE
  } db_state_t;

  // Synchroniser stages; the button idles high (released), switches idle low.
  logic              btn_meta;
  logic              btn_s;
  logic [DATA_W-1:0] sw_meta;
  logic [DATA_W-1:0] sw_s;

  // Debounce FSM and its qualification counter.
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_done;
  logic             press_evt;

  // Held word and handshake state.
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              overrun_q;
  logic              consume;

  // The counter saturates rather than wrapping so a stuck level can never alias.
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign cnt_done = (cnt == CNT_LAST);

  // Two-flop synchronisers on the asynchronous button and switch inputs.
  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset) begin
      btn_meta <= 1'b1;
      btn_s    <= 1'b1;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a two-stage pipeline instead of a single wire.
      btn_meta <= Button;
      btn_s    <= btn_meta;
      sw_meta  <= Switches;
      sw_s     <= sw_meta;
    end
  end

  // Debounce state and counter register.
  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: any opposite sample inside a check window restarts it.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RELEASED: begin
        if (!btn_s) begin
          cnt_nxt   = '0;
          state_nxt = CHK_PRESS;
        end
      end
      CHK_PRESS: begin
        if (btn_s)         state_nxt = RELEASED;
        else if (cnt_done) state_nxt = PRESSED;
        else               cnt_nxt   = cnt_inc;
      end
      PRESSED: begin
        if (btn_s) begin
          cnt_nxt   = '0;
          state_nxt = CHK_RELEASE;
        end
      end
      CHK_RELEASE: begin
        if (!btn_s)        state_nxt = PRESSED;
        else if (cnt_done) state_nxt = RELEASED;
        else               cnt_nxt   = cnt_inc;
      end
      default: state_nxt = RELEASED;
    endcase
  end

  // Outputs of the debouncer: a one-cycle press event and the debounced level.
  always_comb begin
    press_evt = (state == CHK_PRESS) && !btn_s && cnt_done;
    btn_level = (state == PRESSED) || (state == CHK_RELEASE);
  end

  // A consume needs a held word; a request against an empty port just waits.
  assign consume = port.in_req && valid_q;

  // Capture on press, drop valid on consume; a press at the consume edge reloads
  // the port, and overrun only flags a word that was lost without being acked.
  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (press_evt) begin
        data_q  <= sw_s;
        valid_q <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end

      if (press_evt && valid_q && !consume) overrun_q <= 1'b1;
      else if (port.clr_overrun)            overrun_q <= 1'b0;
    end
  end

  assign port.data_out = data_q;
  assign port.valid    = valid_q;
  assign port.in_ack   = consume;
  assign port.overrun  = overrun_q;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Self-checking bench for input_port_ctrl with a short debounce window.
// A run-length reference model (consecutive opposite samples of the synchronised
// button) predicts every output each cycle; directed tables and sequences pin
// the latency, bounce, handshake, overrun, simultaneous and reset corners.
module tb_input_port_ctrl;

  localparam int D  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          button;
  logic [DW-1:0] switches;
  logic          btn_level;

  int n_cmp = 0;
  int n_bad = 0;

  input_port_ctrl_if #(.DATA_W(DW)) port_if ();

  input_port_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (8),
    .DATA_W         (DW)
  ) dut (
    .Clock    (clk),
    .n_reset  (n_reset),
    .Button   (button),
    .Switches (switches),
    .port     (port_if),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Debounced level flips once D+1 consecutive synchronised samples disagree
  // with it; a flip to pressed captures the synchronised switch word.
  logic          m_b1, m_b2;
  logic [DW-1:0] m_w1, m_w2;
  logic          m_level;
  int            m_run;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ov;
  int            m_presses = 0;

  function automatic void model_reset();
    m_b1    = 1'b1;
    m_b2    = 1'b1;
    m_w1    = '0;
    m_w2    = '0;
    m_level = 1'b0;
    m_run   = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
  endfunction

  // True when the coming edge is the one that accepts a press.
  function automatic logic model_press_next();
    return (m_level == 1'b0) && (m_b2 == 1'b0) && (m_run + 1 == D + 1);
  endfunction

  function automatic void model_edge();
    logic pressed_s;
    logic press;
    logic consume;
    pressed_s = ~m_b2;
    press     = 1'b0;
    consume   = port_if.in_req && m_valid;
    if (pressed_s != m_level) m_run++;
    else                      m_run = 0;
    if (m_run == D + 1) begin
      m_level = pressed_s;
      m_run   = 0;
      press   = pressed_s;
    end
    if (press && m_valid && !consume) m_ov = 1'b1;
    else if (port_if.clr_overrun)     m_ov = 1'b0;
    if (press) begin
      m_data  = m_w2;
      m_valid = 1'b1;
      m_presses++;
    end else if (consume) begin
      m_valid = 1'b0;
    end
    m_b2 = m_b1;
    m_b1 = button;
    m_w2 = m_w1;
    m_w1 = switches;
  endfunction

  // ---------------------------------------------------------------- stepping
  // Called at a falling edge: apply inputs and settle before sampling.
  task automatic drive(input logic b, input logic [DW-1:0] sw, input logic req, input logic clr);
    button              = b;
    switches            = sw;
    port_if.in_req      = req;
    port_if.clr_overrun = clr;
    #1;
  endtask

  // Advance the model across the rising edge and return to the next falling edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_check(input string tag);
    check_bit ({tag, ".valid"},     port_if.valid,    m_valid);
    check_bit ({tag, ".in_ack"},    port_if.in_ack,   m_valid && port_if.in_req);
    check_bit ({tag, ".overrun"},   port_if.overrun,  m_ov);
    check_bit ({tag, ".btn_level"}, btn_level,        m_level);
    check_word({tag, ".data_out"},  port_if.data_out, m_data);
  endtask

  task automatic release_idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, switches, 1'b0, 1'b0);
      model_check("idle");
      tick();
    end
  endtask

  // Hold the button until one capture edge passes; a fresh press from a settled
  // release must take exactly D+3 edges.
  task automatic press(input logic [DW-1:0] sw);
    int p0;
    int k;
    p0 = m_presses;
    for (k = 0; k < 40; k++) begin
      drive(1'b0, sw, 1'b0, 1'b0);
      model_check("press");
      tick();
      if (m_presses != p0) break;
    end
    check_int("press_latency", k + 1, D + 3);
    drive(1'b0, sw, 1'b0, 1'b0);
    check_bit ("press.valid", port_if.valid, 1'b1);
    check_word("press.word",  port_if.data_out, sw);
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic          b;
    logic [DW-1:0] sw;
    logic          req;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_ack;
    logic          e_lvl;
  } vec_t;

  vec_t tbl[21];

  int   rises;
  logic prev_valid;
  int   first_row;
  logic pat[7];
  int   run_left;
  logic cur_b;

  initial begin
    n_reset             = 1'b0;
    button              = 1'b1;
    switches            = '0;
    port_if.in_req      = 1'b0;
    port_if.clr_overrun = 1'b0;
    model_reset();

    // Reset state.
    #12;
    check_bit ("reset.valid",     port_if.valid,    1'b0);
    check_bit ("reset.in_ack",    port_if.in_ack,   1'b0);
    check_bit ("reset.overrun",   port_if.overrun,  1'b0);
    check_bit ("reset.btn_level", btn_level,        1'b0);
    check_word("reset.data_out",  port_if.data_out, 16'h0000);
    @(negedge clk);
    n_reset = 1'b1;

    // Clean press of 16'h00A5, then a consume and a request against an empty port.
    for (int r = 0; r < 21; r++) begin
      tbl[r].b       = (r < 20) ? 1'b0 : 1'b1;
      tbl[r].sw      = 16'h00A5;
      tbl[r].req     = (r >= 8 && r <= 10);
      tbl[r].e_valid = (r == 7 || r == 8);
      tbl[r].e_data  = (r >= 7) ? 16'h00A5 : 16'h0000;
      tbl[r].e_ack   = (r == 8);
      tbl[r].e_lvl   = (r >= 7);
    end
    rises      = 0;
    prev_valid = 1'b0;
    for (int r = 0; r < 21; r++) begin
      drive(tbl[r].b, tbl[r].sw, tbl[r].req, 1'b0);
      check_bit ($sformatf("clean[%0d].valid", r),     port_if.valid,    tbl[r].e_valid);
      check_word($sformatf("clean[%0d].data", r),      port_if.data_out, tbl[r].e_data);
      check_bit ($sformatf("clean[%0d].in_ack", r),    port_if.in_ack,   tbl[r].e_ack);
      check_bit ($sformatf("clean[%0d].overrun", r),   port_if.overrun,  1'b0);
      check_bit ($sformatf("clean[%0d].btn_level", r), btn_level,        tbl[r].e_lvl);
      if (port_if.valid && !prev_valid) rises++;
      prev_valid = port_if.valid;
      tick();
    end
    check_int("clean.captures", rises, 1);
    release_idle(12);

    // Handshake with 16'h1234: one-cycle ack, valid drops, a second request is ignored.
    press(16'h1234);
    drive(1'b0, 16'h1234, 1'b1, 1'b0);
    check_bit ("hs.ack",  port_if.in_ack,   1'b1);
    check_word("hs.data", port_if.data_out, 16'h1234);
    tick();
    drive(1'b0, 16'h1234, 1'b1, 1'b0);
    check_bit("hs.valid_drop", port_if.valid,  1'b0);
    check_bit("hs.second_req", port_if.in_ack, 1'b0);
    tick();
    release_idle(12);

    // Overrun: two presses with no request; the second word wins and the flag sets.
    press(16'h0001);
    release_idle(12);
    press(16'h0002);
    check_word("ovr.data",    port_if.data_out, 16'h0002);
    check_bit ("ovr.overrun", port_if.overrun,  1'b1);
    tick();
    drive(1'b0, 16'h0002, 1'b0, 1'b1);
    model_check("ovr_clr");
    tick();
    drive(1'b0, 16'h0002, 1'b0, 1'b0);
    check_bit("ovr.cleared", port_if.overrun, 1'b0);
    tick();
    release_idle(12);

    // Simultaneous: the request lands exactly on the accepting edge.
    first_row = -1;
    for (int k = 0; k < 40; k++) begin
      logic req;
      req = model_press_next();
      drive(1'b0, 16'h0BEE, req, 1'b0);
      model_check("sim");
      if (req) begin
        check_bit ("sim.ack",      port_if.in_ack,   1'b1);
        check_word("sim.old_word", port_if.data_out, 16'h0002);
        tick();
        drive(1'b0, 16'h0BEE, 1'b0, 1'b0);
        check_bit ("sim.valid",    port_if.valid,    1'b1);
        check_word("sim.new_word", port_if.data_out, 16'h0BEE);
        check_bit ("sim.overrun",  port_if.overrun,  1'b0);
        first_row = k;
        tick();
        break;
      end
      tick();
    end
    check_int("sim.edge_found", first_row, D + 2);
    release_idle(12);

    // Bounce: 0,0,1,0,0,1,1 then steady low; only the last steady run qualifies.
    drive(1'b1, 16'h0C0C, 1'b1, 1'b0);
    model_check("bnc_consume");
    tick();
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rises      = 0;
    prev_valid = 1'b0;
    first_row  = -1;
    for (int r = 0; r < 24; r++) begin
      drive((r < 7) ? pat[r] : 1'b0, 16'h0C0C, 1'b0, 1'b0);
      model_check("bounce");
      if (port_if.valid && !prev_valid) begin
        rises++;
        if (first_row < 0) first_row = r;
      end
      prev_valid = port_if.valid;
      tick();
    end
    check_int ("bounce.first_valid_row", first_row, 7 + D + 3);
    check_int ("bounce.captures",        rises,     1);
    check_word("bounce.word",            port_if.data_out, 16'h0C0C);
    release_idle(12);

    // Reset mid-qualification with a held word and overrun set.
    press(16'h5555);
    check_bit("rst.pre_overrun", port_if.overrun, 1'b1);
    tick();
    release_idle(12);
    for (int r = 0; r < 4; r++) begin
      drive(1'b0, 16'h7777, 1'b0, 1'b0);
      model_check("rst_pre");
      tick();
    end
    drive(1'b0, 16'h7777, 1'b0, 1'b0);
    n_reset = 1'b0;
    #1;
    check_bit ("rst.valid",     port_if.valid,    1'b0);
    check_bit ("rst.overrun",   port_if.overrun,  1'b0);
    check_bit ("rst.btn_level", btn_level,        1'b0);
    check_word("rst.data_out",  port_if.data_out, 16'h0000);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    press(16'h7777);
    tick();
    release_idle(12);

    // Randomised traffic: runs of button levels, some shorter than the window.
    cur_b    = 1'b1;
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        cur_b    = 1'($urandom_range(0, 1));
        run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 12));
      end
      run_left--;
      drive(cur_b, 16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      model_check("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
